// File: rtl/ysyx_22050019_axi_rd_arbiter_if.sv
// ============================================================================
// Module      : ysyx_22050019_axi_rd_arbiter_if
// Description : Single-beat AXI4-Lite-style read channel bundle (AR + R).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ysyx_22050019_axi_rd_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    // Side that issues reads (IFU/LSU, or the arbiter toward memory).
    modport master (
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    // Side that serves reads (memory, or the arbiter toward IFU/LSU).
    modport slave (
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// ============================================================================
// Module      : ysyx_22050019_axi_rd_arbiter
// Description : Two-master (IFU=m0, LSU=m1) to one-slave single-outstanding
//               read arbiter. Define AXI_ARB_RR_EN for round-robin, otherwise
//               fixed priority with the LSU winning.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_22050019_axi_rd_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,   // active-high despite the name
    ysyx_22050019_axi_rd_arbiter_if.slave  m0,
    ysyx_22050019_axi_rd_arbiter_if.slave  m1,
    ysyx_22050019_axi_rd_arbiter_if.master s,
    output logic                          busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;

    logic [ADDR_W-1:0] w_g_araddr;
    logic              w_g_arvalid;
    logic              w_g_rready;
    logic              w_pick;
    logic              w_in_addr;
    logic              w_in_data;
    logic              w_r0_sel;
    logic              w_r1_sel;
    logic [DATA_W-1:0] w_zero_data;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign w_g_araddr  = grant_q ? m1.araddr  : m0.araddr;
    assign w_g_arvalid = grant_q ? m1.arvalid : m0.arvalid;
    assign w_g_rready  = grant_q ? m1.rready  : m0.rready;

`ifdef AXI_ARB_RR_EN
    assign w_pick = (m0.arvalid & m1.arvalid) ? ~last_q : m1.arvalid;
`else
    assign w_pick = m1.arvalid;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0.arvalid | m1.arvalid) begin
                    state_d = ST_ADDR;
                    grant_d = w_pick;
                end
            end
            ST_ADDR: begin
                // A granted master that drops arvalid keeps its grant.
                if (w_g_arvalid & s.arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s.rvalid & w_g_rready) begin
                    state_d = ST_IDLE;
`ifdef AXI_ARB_RR_EN
                    last_d  = grant_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Routing depends only on registered state, so IDLE has no arvalid->s_* path.
    assign w_in_addr   = (state_q == ST_ADDR);
    assign w_in_data   = (state_q == ST_DATA);
    assign w_r0_sel    = w_in_data & ~grant_q;
    assign w_r1_sel    = w_in_data &  grant_q;
    assign w_zero_data = '0;

    assign s.araddr  = w_in_addr ? w_g_araddr : '0;
    assign s.arvalid = w_in_addr & w_g_arvalid;
    assign s.rready  = w_in_data & w_g_rready;

    assign m0.arready = w_in_addr & ~grant_q & s.arready;
    assign m1.arready = w_in_addr &  grant_q & s.arready;

    assign m0.rvalid = w_r0_sel & s.rvalid;
    assign m0.rdata  = w_r0_sel ? s.rdata : w_zero_data;
    assign m0.rresp  = w_r0_sel ? s.rresp : 2'b00;

    assign m1.rvalid = w_r1_sel & s.rvalid;
    assign m1.rdata  = w_r1_sel ? s.rdata : w_zero_data;
    assign m1.rresp  = w_r1_sel ? s.rresp : 2'b00;

    assign busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_axi_rd_arbiter.sv
// ============================================================================
// Module      : tb_ysyx_22050019_axi_rd_arbiter
// Description : Self-checking bench: directed vector table, corner sequences
//               and a randomized run against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_22050019_axi_rd_arbiter;

    typedef struct packed {
        logic        m0v;
        logic [63:0] m0a;
        logic        m1v;
        logic [63:0] m1a;
        logic        sary;
        logic        srv;
        logic [63:0] srd;
        logic [1:0]  srr;
        logic        m0rr;
        logic        m1rr;
    } in_t;

    typedef struct packed {
        logic        busy;
        logic        sav;
        logic [63:0] saa;
        logic        srrdy;
        logic        m0ary;
        logic        m1ary;
        logic        m0rv;
        logic        m1rv;
        logic [63:0] m0rd;
        logic [63:0] m1rd;
        logic [1:0]  m0rs;
        logic [1:0]  m1rs;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;

    ysyx_22050019_axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) m0_bus ();
    ysyx_22050019_axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) m1_bus ();
    ysyx_22050019_axi_rd_arbiter_if #(.ADDR_W(64), .DATA_W(64)) s_bus ();

    ysyx_22050019_axi_rd_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [63:0] c_a  = 64'h0000_0000_8000_0000;
    logic [63:0] c_b  = 64'h0000_0000_8000_1000;
    logic [63:0] c_d  = 64'h0000_0013_0000_0093;
    logic [63:0] c_d1 = 64'h1111_2222_3333_4444;
    logic [63:0] c_d2 = 64'hDEAD_BEEF_0BAD_F00D;
    logic [63:0] c_z  = 64'h0;

    function automatic in_t mk_in(int m0v, logic [63:0] m0a, int m1v, logic [63:0] m1a,
                                  int sary, int srv, logic [63:0] srd, int srr,
                                  int m0rr, int m1rr);
        in_t r;
        r.m0v = 1'(m0v);  r.m0a = m0a;  r.m1v = 1'(m1v);  r.m1a = m1a;
        r.sary = 1'(sary); r.srv = 1'(srv); r.srd = srd; r.srr = 2'(srr);
        r.m0rr = 1'(m0rr); r.m1rr = 1'(m1rr);
        return r;
    endfunction

    function automatic out_t mk_out(int bsy, int sav, logic [63:0] saa, int srrdy,
                                    int m0ary, int m1ary, int m0rv, int m1rv,
                                    logic [63:0] m0rd, logic [63:0] m1rd, int m0rs, int m1rs);
        out_t r;
        r.busy = 1'(bsy); r.sav = 1'(sav); r.saa = saa; r.srrdy = 1'(srrdy);
        r.m0ary = 1'(m0ary); r.m1ary = 1'(m1ary); r.m0rv = 1'(m0rv); r.m1rv = 1'(m1rv);
        r.m0rd = m0rd; r.m1rd = m1rd; r.m0rs = 2'(m0rs); r.m1rs = 2'(m1rs);
        return r;
    endfunction

    task automatic drive(input in_t v);
        m0_bus.arvalid = v.m0v;  m0_bus.araddr = v.m0a;  m0_bus.rready = v.m0rr;
        m1_bus.arvalid = v.m1v;  m1_bus.araddr = v.m1a;  m1_bus.rready = v.m1rr;
        s_bus.arready  = v.sary; s_bus.rvalid  = v.srv;
        s_bus.rdata    = v.srd;  s_bus.rresp   = v.srr;
    endtask

    function automatic out_t sample();
        out_t r;
        r.busy = busy; r.sav = s_bus.arvalid; r.saa = s_bus.araddr; r.srrdy = s_bus.rready;
        r.m0ary = m0_bus.arready; r.m1ary = m1_bus.arready;
        r.m0rv = m0_bus.rvalid; r.m1rv = m1_bus.rvalid;
        r.m0rd = m0_bus.rdata; r.m1rd = m1_bus.rdata;
        r.m0rs = m0_bus.rresp; r.m1rs = m1_bus.rresp;
        return r;
    endfunction

    task automatic check_out(input string name, input out_t exp);
        out_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        drive('0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    function automatic logic [63:0] fdat(logic [63:0] a);
        return {a[31:0], ~a[31:0]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [1:0] fresp(logic [63:0] a);
        return a[4:3];
    endfunction

    // Winner when the arbiter samples requests while idle.
    function automatic int pick(logic r0, logic r1, logic lst);
        if (r0 && r1) begin
`ifdef AXI_ARB_RR_EN
            return lst ? 0 : 1;
`else
            return (lst === 1'bx) ? 1 : 1;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    vec_t        vq[$];
    logic        ord[$];
    int          ocyc[$];
    logic        mreq[2];
    logic        mwait[2];
    logic [63:0] maddr[2];
    logic [63:0] mexp[2];
    int          ndone[2];
    logic        spend, srv;
    logic [63:0] saddr;
    int          own;
    logic        ardone, mlast;
    in_t         vi;
    out_t        eo;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // ---------------- directed vector table ----------------
        vq.push_back('{mk_in(1,c_a,0,c_z,1,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,0,c_z,1,0,c_z,0,1,1), mk_out(1,1,c_a,0,1,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_z,1,0,c_z,0,1,1), mk_out(1,0,c_z,1,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_z,1,1,c_d,0,1,1), mk_out(1,0,c_z,1,0,0,1,0,c_d,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_z,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        // both request: LSU first in either arbitration mode at this point
        vq.push_back('{mk_in(1,c_a,1,c_b,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,1,c_b,0,0,c_z,0,1,1), mk_out(1,1,c_b,0,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,1,c_b,1,0,c_z,0,1,1), mk_out(1,1,c_b,0,0,1,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,0,c_b,1,1,c_d1,2,1,0), mk_out(1,0,c_z,0,0,0,0,1,c_z,c_d1,0,2)});
        vq.push_back('{mk_in(1,c_a,0,c_b,1,1,c_d1,2,1,1), mk_out(1,0,c_z,1,0,0,0,1,c_z,c_d1,0,2)});
        vq.push_back('{mk_in(1,c_a,0,c_b,1,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,0,c_b,1,0,c_z,0,1,1), mk_out(1,1,c_a,0,1,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,1,1,c_d2,0,1,1), mk_out(1,0,c_z,1,0,0,1,0,c_d2,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        // granted master drops arvalid in ADDR: grant kept, s_arvalid low
        vq.push_back('{mk_in(1,c_a,0,c_b,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,1,0,c_z,0,1,1), mk_out(1,0,c_a,0,1,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,0,c_b,1,0,c_z,0,1,1), mk_out(1,1,c_a,0,1,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,0,1,c_d,0,1,1), mk_out(1,0,c_z,1,0,0,1,0,c_d,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        // backpressure: 5 cycles without arready, then 3 cycles without m0_rready
        vq.push_back('{mk_in(1,c_a,0,c_b,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});
        for (int k = 0; k < 5; k++)
            vq.push_back('{mk_in(1,c_a,0,c_b,0,0,c_z,0,1,1), mk_out(1,1,c_a,0,0,0,0,0,c_z,c_z,0,0)});
        vq.push_back('{mk_in(1,c_a,0,c_b,1,0,c_z,0,1,1), mk_out(1,1,c_a,0,1,0,0,0,c_z,c_z,0,0)});
        for (int k = 0; k < 3; k++)
            vq.push_back('{mk_in(0,c_a,0,c_b,0,1,c_d,0,0,1), mk_out(1,0,c_z,0,0,0,1,0,c_d,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,0,1,c_d,0,1,1), mk_out(1,0,c_z,1,0,0,1,0,c_d,c_z,0,0)});
        vq.push_back('{mk_in(0,c_a,0,c_b,0,0,c_z,0,1,1), mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0)});

        // ---------------- reset state ----------------
        rst_n = 1'b1;
        drive(mk_in(1,c_a,1,c_b,1,1,c_d,2,1,1));
        #12;
        check_out("reset_state", mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0));
        drive('0);
        @(negedge clk);
        rst_n = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk); #1;
            drive(vq[k].i);
            #1;
            check_out($sformatf("vec%0d", k), vq[k].o);
        end

        // ---------------- asynchronous reset in DATA ----------------
        @(posedge clk); #1;
        drive(mk_in(1,c_a,0,c_z,1,0,c_z,0,0,0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(mk_in(0,c_a,0,c_z,1,1,c_d,0,0,0));
        #1;
        check_out("pre_reset_data", mk_out(1,0,c_z,0,0,0,1,0,c_d,c_z,0,0));
        #1 rst_n = 1'b1;
        #1;
        check_out("reset_mid_data", mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0));
        @(posedge clk);
        drive('0);
        @(negedge clk);
        rst_n = 1'b0;

        // fresh m0 request after release
        @(posedge clk); #1;
        drive(mk_in(1,c_a,0,c_z,1,0,c_z,0,1,1));
        #1 check_out("post_rst_idle", mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0));
        @(posedge clk); #1;
        #1 check_out("post_rst_addr", mk_out(1,1,c_a,0,1,0,0,0,c_z,c_z,0,0));
        @(posedge clk); #1;
        drive(mk_in(0,c_a,0,c_z,0,1,c_d,0,1,1));
        #1 check_out("post_rst_data", mk_out(1,0,c_z,1,0,0,1,0,c_d,c_z,0,0));
        @(posedge clk); #1;
        drive('0);
        #1 check_out("post_rst_done", mk_out(0,0,c_z,0,0,0,0,0,c_z,c_z,0,0));

        // ---------------- continuous dual requests from reset ----------------
        do_reset();
        drive(mk_in(1,c_a,1,c_b,1,1,c_d,0,1,1));
        for (int c = 0; c < 40 && ord.size() < 4; c++) begin
            @(posedge clk); #1;
            if (s_bus.arvalid && s_bus.arready) begin
                ord.push_back(s_bus.araddr == c_b);
                ocyc.push_back(c);
            end
        end
        if (ord.size() < 4) begin
            checks++; errors++;
            $display("FAIL dual_grants: got %0d grants expected 4 within 40 cycles", ord.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
`ifdef AXI_ARB_RR_EN
                check_bit($sformatf("dual_grant%0d", k), ord[k], 1'(k % 2));
`else
                check_bit($sformatf("dual_grant%0d", k), ord[k], 1'b1);
`endif
            end
            checks++;
            if (ocyc[3] - ocyc[0] != 9) begin
                errors++;
                $display("FAIL dual_spacing: got %0d cycles expected 9", ocyc[3] - ocyc[0]);
            end
        end

        // ---------------- randomized run vs transaction model ----------------
        do_reset();
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 1'b0; mwait[i] = 1'b0; ndone[i] = 0;
            maddr[i] = 64'h8000_0000; mexp[i] = '0;
        end
        spend = 1'b0; srv = 1'b0; saddr = '0;
        own = -1; ardone = 1'b0; mlast = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (!mreq[i] && !mwait[i] && $urandom_range(2) == 0) begin
                    mreq[i]  = 1'b1;
                    maddr[i] = 64'h8000_0000 + 64'(i) * 64'h10_0000 + 64'($urandom_range(4095)) * 8;
                end
            end
            if (spend && !srv && $urandom_range(2) != 0) srv = 1'b1;
            vi.m0v = mreq[0]; vi.m0a = maddr[0]; vi.m0rr = 1'($urandom_range(1));
            vi.m1v = mreq[1]; vi.m1a = maddr[1]; vi.m1rr = 1'($urandom_range(1));
            vi.sary = 1'($urandom_range(1));
            vi.srv  = srv;
            vi.srd  = srv ? fdat(saddr) : {$urandom, $urandom};
            vi.srr  = srv ? fresp(saddr) : 2'($urandom_range(3));
            drive(vi);
            #1;

            eo = '0;
            eo.busy = (own >= 0);
            if (own >= 0 && !ardone) begin
                eo.sav = (own == 1) ? vi.m1v : vi.m0v;
                eo.saa = (own == 1) ? vi.m1a : vi.m0a;
                if (own == 1) eo.m1ary = vi.sary; else eo.m0ary = vi.sary;
            end
            if (own >= 0 && ardone) begin
                if (own == 1) begin
                    eo.m1rv = vi.srv; eo.m1rd = vi.srd; eo.m1rs = vi.srr; eo.srrdy = vi.m1rr;
                end else begin
                    eo.m0rv = vi.srv; eo.m0rd = vi.srd; eo.m0rs = vi.srr; eo.srrdy = vi.m0rr;
                end
            end
            check_out($sformatf("rand_c%0d", cyc), eo);

            if (mreq[0] && m0_bus.arready) begin mreq[0] = 1'b0; mwait[0] = 1'b1; mexp[0] = maddr[0]; end
            if (mreq[1] && m1_bus.arready) begin mreq[1] = 1'b0; mwait[1] = 1'b1; mexp[1] = maddr[1]; end
            if (m0_bus.rvalid && vi.m0rr) begin
                checks++;
                if (m0_bus.rdata !== fdat(mexp[0]) || m0_bus.rresp !== fresp(mexp[0])) begin
                    errors++;
                    $display("FAIL rand_m0_data: got %h/%0d expected %h/%0d", m0_bus.rdata,
                             m0_bus.rresp, fdat(mexp[0]), fresp(mexp[0]));
                end
                mwait[0] = 1'b0; ndone[0]++;
            end
            if (m1_bus.rvalid && vi.m1rr) begin
                checks++;
                if (m1_bus.rdata !== fdat(mexp[1]) || m1_bus.rresp !== fresp(mexp[1])) begin
                    errors++;
                    $display("FAIL rand_m1_data: got %h/%0d expected %h/%0d", m1_bus.rdata,
                             m1_bus.rresp, fdat(mexp[1]), fresp(mexp[1]));
                end
                mwait[1] = 1'b0; ndone[1]++;
            end
            if (s_bus.arvalid && vi.sary) begin spend = 1'b1; saddr = s_bus.araddr; end
            if (srv && s_bus.rready) begin srv = 1'b0; spend = 1'b0; end

            if (own < 0) begin
                if (vi.m0v || vi.m1v) begin
                    own = pick(vi.m0v, vi.m1v, mlast);
                    ardone = 1'b0;
                end
            end else if (!ardone) begin
                if (((own == 1) ? vi.m1v : vi.m0v) && vi.sary) ardone = 1'b1;
            end else if (vi.srv && ((own == 1) ? vi.m1rr : vi.m0rr)) begin
                mlast = (own == 1);
                own = -1;
            end
        end
        checks++;
        if (ndone[0] < 1 || ndone[1] < 1) begin
            errors++;
            $display("FAIL rand_progress: got m0=%0d m1=%0d completions expected at least 1 each",
                     ndone[0], ndone[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
